// File: rtl/img_proc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : img_proc_pkg                                                     |
// | Purpose : Shared definitions for the image job scheduler: default colour   |
// |           value width, job operation codes, scheduler state encoding and   |
// |           a mode-validity helper.                                          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package img_proc_pkg;

   localparam int COLOR_SIZE = 8;

   localparam logic [1:0] MODE_THRESH = 2'b01;
   localparam logic [1:0] MODE_BRIGHT = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_STREAM = 2'b01,
      S_DONE   = 2'b10
   } sched_state_t;

   // Only the two defined operations may raise a request; 00 and 11 never do.
   function automatic logic mode_is_valid(input logic [1:0] mode);
      return (mode == MODE_THRESH) || (mode == MODE_BRIGHT);
   endfunction

endpackage
`default_nettype wire

// File: rtl/img_job_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : img_job_scheduler_if                                           |
// | Purpose   : Bundles the two slave job ports, the shared processor port and |
// |             the job status outputs of the scheduler.                       |
// | Modports  : master - scheduler view (drives rdy, proc_* and status)        |
// |             slave  - environment view (slaves and processor)               |
// | Rev       : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface img_job_scheduler_if #(
   parameter int DATA_WIDTH = 32,
   parameter int COLOR_SIZE = 8,
   parameter int CNT_W      = 16
);
   logic [1:0]            slv0_mode;
   logic                  slv0_data_valid;
   logic                  slv0_last;
   logic [COLOR_SIZE-1:0] slv0_proc_val;
   logic [DATA_WIDTH-1:0] slv0_data;
   logic                  slv0_rdy;

   logic [1:0]            slv1_mode;
   logic                  slv1_data_valid;
   logic                  slv1_last;
   logic [COLOR_SIZE-1:0] slv1_proc_val;
   logic [DATA_WIDTH-1:0] slv1_data;
   logic                  slv1_rdy;

   logic                  proc_vld;
   logic                  proc_last;
   logic [DATA_WIDTH-1:0] proc_data;
   logic [1:0]            proc_mode;
   logic [COLOR_SIZE-1:0] proc_val;
   logic                  proc_rdy;

   logic                  mstr0_cmplt;
   logic                  job_owner;
   logic                  busy;
   logic [CNT_W-1:0]      job_words;

   modport master (
      input  slv0_mode, slv0_data_valid, slv0_last, slv0_proc_val, slv0_data,
      input  slv1_mode, slv1_data_valid, slv1_last, slv1_proc_val, slv1_data,
      input  proc_rdy,
      output slv0_rdy, slv1_rdy,
      output proc_vld, proc_last, proc_data, proc_mode, proc_val,
      output mstr0_cmplt, job_owner, busy, job_words
   );

   modport slave (
      output slv0_mode, slv0_data_valid, slv0_last, slv0_proc_val, slv0_data,
      output slv1_mode, slv1_data_valid, slv1_last, slv1_proc_val, slv1_data,
      output proc_rdy,
      input  slv0_rdy, slv1_rdy,
      input  proc_vld, proc_last, proc_data, proc_mode, proc_val,
      input  mstr0_cmplt, job_owner, busy, job_words
   );
endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rr_arb2                                                          |
// | Purpose : Two-way round-robin selector. On a tie the requester not served  |
// |           last wins; a single requester always wins.                       |
// | Ports   : clk, rst_n  - clock, async active-low reset                      |
// |           req[1:0]    - request vector                                     |
// |           update      - grant taken this cycle, remember the winner        |
// |           gnt_idx     - index of the selected requester                    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module rr_arb2 (
   input  wire        clk,
   input  wire        rst_n,
   input  wire  [1:0] req,
   input  wire        update,
   output logic       gnt_idx
);

   // Last-served index; resets to 1 so slave 0 takes the first tie.
   logic r_last;

   always_comb begin
      gnt_idx = req[1];
      if (req == 2'b11) begin
         gnt_idx = ~r_last;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= 1'b1;
      end else if (update) begin
         r_last <= gnt_idx;
      end
   end

endmodule
`default_nettype wire

// File: rtl/img_job_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : img_job_scheduler                                                |
// | Purpose : Arbitrates jobs from two slaves onto one shared pixel processor. |
// |           A granted job is streamed word by word as a combinational        |
// |           pass-through; mode and value are frozen for the whole job.       |
// | Ports   : clk, rst_n - clock, async active-low reset                       |
// |           bus        - img_job_scheduler_if.master (slave ports, processor |
// |                        port, cmplt/owner/busy/job_words status)            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module img_job_scheduler #(
   parameter int DATA_WIDTH = 32,
   parameter int COLOR_SIZE = 8,
   parameter int CNT_W      = 16
) (
   input  wire                 clk,
   input  wire                 rst_n,
   img_job_scheduler_if.master bus
);
   import img_proc_pkg::*;

   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

   sched_state_t          r_state;
   sched_state_t          w_next;
   logic [1:0]            w_req;
   logic                  w_gnt_idx;
   logic                  w_grant;
   logic                  w_xfer;
   logic                  w_sel_vld;
   logic                  w_sel_last;
   logic [DATA_WIDTH-1:0] w_sel_data;
   logic [CNT_W-1:0]      w_cnt_inc;

   logic                  r_owner;
   logic [1:0]            r_mode;
   logic [COLOR_SIZE-1:0] r_val;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      r_job_words;

   assign w_req[0] = bus.slv0_data_valid && mode_is_valid(bus.slv0_mode);
   assign w_req[1] = bus.slv1_data_valid && mode_is_valid(bus.slv1_mode);

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (w_req),
      .update  (w_grant),
      .gnt_idx (w_gnt_idx)
   );

   // Owner-side mux of the streaming signals.
   assign w_sel_vld  = r_owner ? bus.slv1_data_valid : bus.slv0_data_valid;
   assign w_sel_last = r_owner ? bus.slv1_last       : bus.slv0_last;
   assign w_sel_data = r_owner ? bus.slv1_data       : bus.slv0_data;

   assign w_xfer    = (r_state == S_STREAM) && w_sel_vld && bus.proc_rdy;
   assign w_cnt_inc = (&r_cnt) ? r_cnt : (r_cnt + c_cnt_one);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next          = r_state;
      w_grant         = 1'b0;
      bus.proc_vld    = 1'b0;
      bus.proc_last   = 1'b0;
      bus.proc_data   = '0;
      bus.slv0_rdy    = 1'b0;
      bus.slv1_rdy    = 1'b0;
      bus.mstr0_cmplt = 1'b0;
      bus.busy        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (|w_req) begin
               w_grant = 1'b1;
               w_next  = S_STREAM;
            end
         end
         S_STREAM: begin
            bus.busy      = 1'b1;
            bus.proc_vld  = w_sel_vld;
            bus.proc_last = w_sel_last;
            bus.proc_data = w_sel_data;
            if (r_owner) begin
               bus.slv1_rdy = bus.proc_rdy;
            end else begin
               bus.slv0_rdy = bus.proc_rdy;
            end
            if (w_xfer && w_sel_last) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            bus.mstr0_cmplt = 1'b1;
            w_next          = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Job context: captured at grant, held until the next grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner     <= 1'b0;
         r_mode      <= 2'b00;
         r_val       <= '0;
         r_cnt       <= '0;
         r_job_words <= '0;
      end else if (w_grant) begin
         r_owner <= w_gnt_idx;
         r_mode  <= w_gnt_idx ? bus.slv1_mode     : bus.slv0_mode;
         r_val   <= w_gnt_idx ? bus.slv1_proc_val : bus.slv0_proc_val;
         r_cnt   <= '0;
      end else if (w_xfer) begin
         r_cnt <= w_cnt_inc;
         // Publish the count on the closing transfer so it is valid in DONE.
         if (w_sel_last) begin
            r_job_words <= w_cnt_inc;
         end
      end
   end

   assign bus.proc_mode = r_mode;
   assign bus.proc_val  = r_val;
   assign bus.job_owner = r_owner;
   assign bus.job_words = r_job_words;

endmodule
`default_nettype wire

// File: tb/tb_img_job_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_img_job_scheduler                                             |
// | Purpose : Directed self-checking bench for img_job_scheduler. Inputs are   |
// |           driven on the falling edge and outputs sampled 1ns later.        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_img_job_scheduler;
   import img_proc_pkg::*;

   localparam int DW = 32;
   localparam int CS = 8;
   localparam int CW = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;

   int rdy_pat [5] = '{1, 0, 0, 1, 1};
   int exp_idx [5] = '{0, 1, 1, 1, 2};

   img_job_scheduler_if #(.DATA_WIDTH(DW), .COLOR_SIZE(CS), .CNT_W(CW)) bus ();

   img_job_scheduler #(.DATA_WIDTH(DW), .COLOR_SIZE(CS), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      bus.slv0_mode = 2'b00; bus.slv0_data_valid = 1'b0; bus.slv0_last = 1'b0;
      bus.slv0_proc_val = '0; bus.slv0_data = '0;
      bus.slv1_mode = 2'b00; bus.slv1_data_valid = 1'b0; bus.slv1_last = 1'b0;
      bus.slv1_proc_val = '0; bus.slv1_data = '0;
      bus.proc_rdy = 1'b1;
   endtask

   task automatic rst_chk(input string tag);
      chk({tag, "_proc_vld"},  bus.proc_vld,    0);
      chk({tag, "_proc_last"}, bus.proc_last,   0);
      chk({tag, "_proc_data"}, bus.proc_data,   0);
      chk({tag, "_proc_mode"}, bus.proc_mode,   0);
      chk({tag, "_proc_val"},  bus.proc_val,    0);
      chk({tag, "_cmplt"},     bus.mstr0_cmplt, 0);
      chk({tag, "_owner"},     bus.job_owner,   0);
      chk({tag, "_busy"},      bus.busy,        0);
      chk({tag, "_job_words"}, bus.job_words,   0);
      chk({tag, "_slv0_rdy"},  bus.slv0_rdy,    0);
      chk({tag, "_slv1_rdy"},  bus.slv1_rdy,    0);
   endtask

   initial begin
      clr();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst_chk("rst");
      @(negedge clk); rst_n = 1'b1;

      // T1: slave 0 alone, threshold, 4 words.
      @(negedge clk);
      bus.slv0_data_valid = 1'b1; bus.slv0_mode = MODE_THRESH; bus.slv0_proc_val = 8'h80;
      bus.slv0_data = 32'hA000_0000; bus.slv0_last = 1'b0;
      #1 chk("t1_idle_rdy", bus.slv0_rdy, 0);
      chk("t1_idle_busy", bus.busy, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.slv0_data = 32'hA000_0000 + 32'(i); bus.slv0_last = (i == 3);
         #1;
         chk("t1_vld",   bus.proc_vld,  1);
         chk("t1_data",  bus.proc_data, 32'hA000_0000 + 32'(i));
         chk("t1_last",  bus.proc_last, (i == 3));
         chk("t1_rdy",   bus.slv0_rdy,  1);
         chk("t1_mode",  bus.proc_mode, 2'b01);
         chk("t1_val",   bus.proc_val,  8'h80);
         chk("t1_busy",  bus.busy,      1);
         chk("t1_cmplt", bus.mstr0_cmplt, 0);
      end
      @(negedge clk); clr(); #1;
      chk("t1_done_cmplt", bus.mstr0_cmplt, 1);
      chk("t1_done_words", bus.job_words, 4);
      chk("t1_done_busy",  bus.busy, 0);
      chk("t1_done_vld",   bus.proc_vld, 0);
      chk("t1_done_rdy",   bus.slv0_rdy, 0);
      @(negedge clk); #1;
      chk("t1_post_cmplt", bus.mstr0_cmplt, 0);
      chk("t1_post_words", bus.job_words, 4);

      // Fresh reset so the arbiter pointer starts from its reset value.
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;

      // T2: simultaneous requests, one-word jobs, round-robin order 0,1,0.
      @(negedge clk);
      bus.slv0_data_valid = 1'b1; bus.slv0_mode = MODE_BRIGHT; bus.slv0_proc_val = 8'h11;
      bus.slv0_data = 32'hB000_0000; bus.slv0_last = 1'b1;
      bus.slv1_data_valid = 1'b1; bus.slv1_mode = MODE_THRESH; bus.slv1_proc_val = 8'h22;
      bus.slv1_data = 32'hC000_0000; bus.slv1_last = 1'b1;
      #1 chk("t2_idle_rdy0", bus.slv0_rdy, 0);
      chk("t2_idle_rdy1", bus.slv1_rdy, 0);
      @(negedge clk); #1;
      chk("t2_a_owner", bus.job_owner, 0);
      chk("t2_a_data",  bus.proc_data, 32'hB000_0000);
      chk("t2_a_last",  bus.proc_last, 1);
      chk("t2_a_rdy0",  bus.slv0_rdy, 1);
      chk("t2_a_rdy1",  bus.slv1_rdy, 0);
      chk("t2_a_mode",  bus.proc_mode, 2'b10);
      chk("t2_a_val",   bus.proc_val, 8'h11);
      @(negedge clk); bus.slv0_data = 32'hB000_0001; #1;
      chk("t2_a_cmplt", bus.mstr0_cmplt, 1);
      chk("t2_a_words", bus.job_words, 1);
      chk("t2_a_done_rdy1", bus.slv1_rdy, 0);
      @(negedge clk); #1;
      chk("t2_idle_busy", bus.busy, 0);
      chk("t2_idle_cmplt", bus.mstr0_cmplt, 0);
      @(negedge clk); #1;
      chk("t2_b_owner", bus.job_owner, 1);
      chk("t2_b_busy",  bus.busy, 1);
      chk("t2_b_data",  bus.proc_data, 32'hC000_0000);
      chk("t2_b_rdy1",  bus.slv1_rdy, 1);
      chk("t2_b_rdy0",  bus.slv0_rdy, 0);
      chk("t2_b_mode",  bus.proc_mode, 2'b01);
      chk("t2_b_val",   bus.proc_val, 8'h22);
      @(negedge clk); bus.slv1_data = 32'hC000_0001; #1;
      chk("t2_b_cmplt", bus.mstr0_cmplt, 1);
      @(negedge clk); #1;
      @(negedge clk); #1;
      chk("t2_c_owner", bus.job_owner, 0);
      chk("t2_c_data",  bus.proc_data, 32'hB000_0001);
      chk("t2_c_rdy0",  bus.slv0_rdy, 1);
      @(negedge clk); clr(); #1;
      chk("t2_c_cmplt", bus.mstr0_cmplt, 1);
      chk("t2_c_words", bus.job_words, 1);
      @(negedge clk);

      // T3: slave 1, 3 words, processor stalls two cycles.
      @(negedge clk);
      bus.slv1_data_valid = 1'b1; bus.slv1_mode = MODE_THRESH; bus.slv1_proc_val = 8'h33;
      bus.slv1_data = 32'hD000_0000; bus.slv1_last = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         bus.proc_rdy  = (rdy_pat[c] != 0);
         bus.slv1_data = 32'hD000_0000 + 32'(exp_idx[c]);
         bus.slv1_last = (exp_idx[c] == 2);
         #1;
         chk("t3_vld",   bus.proc_vld, 1);
         chk("t3_data",  bus.proc_data, 32'hD000_0000 + 32'(exp_idx[c]));
         chk("t3_rdy1",  bus.slv1_rdy, rdy_pat[c] != 0);
         chk("t3_rdy0",  bus.slv0_rdy, 0);
         chk("t3_cmplt", bus.mstr0_cmplt, 0);
      end
      @(negedge clk); clr(); #1;
      chk("t3_cmplt_done", bus.mstr0_cmplt, 1);
      chk("t3_words", bus.job_words, 3);
      @(negedge clk);

      // T4: owner changes mode/value mid-job; frozen context expected.
      @(negedge clk);
      bus.slv0_data_valid = 1'b1; bus.slv0_mode = MODE_BRIGHT; bus.slv0_proc_val = 8'h10;
      bus.slv0_data = 32'hE000_0000; bus.slv0_last = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (c == 1) begin
            bus.slv0_mode = MODE_THRESH; bus.slv0_proc_val = 8'h20;
         end
         bus.slv0_data = 32'hE000_0000 + 32'(c); bus.slv0_last = (c == 2);
         #1;
         chk("t4_mode", bus.proc_mode, 2'b10);
         chk("t4_val",  bus.proc_val, 8'h10);
         chk("t4_data", bus.proc_data, 32'hE000_0000 + 32'(c));
      end
      @(negedge clk); clr(); #1;
      chk("t4_cmplt", bus.mstr0_cmplt, 1);
      chk("t4_done_mode", bus.proc_mode, 2'b10);
      chk("t4_done_val",  bus.proc_val, 8'h10);
      chk("t4_words", bus.job_words, 3);
      @(negedge clk);

      // T5: slave 1 presents invalid mode 11; slave 0 served normally.
      @(negedge clk);
      bus.slv1_data_valid = 1'b1; bus.slv1_mode = 2'b11; bus.slv1_proc_val = 8'h44;
      bus.slv1_data = 32'hF000_0000; bus.slv1_last = 1'b1;
      #1 chk("t5_idle_rdy1", bus.slv1_rdy, 0);
      @(negedge clk); #1;
      chk("t5_no_grant_busy", bus.busy, 0);
      chk("t5_no_grant_rdy1", bus.slv1_rdy, 0);
      bus.slv0_data_valid = 1'b1; bus.slv0_mode = MODE_THRESH; bus.slv0_proc_val = 8'h55;
      bus.slv0_data = 32'h5000_0000; bus.slv0_last = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         bus.slv0_data = 32'h5000_0000 + 32'(c); bus.slv0_last = (c == 1);
         #1;
         chk("t5_owner", bus.job_owner, 0);
         chk("t5_rdy0",  bus.slv0_rdy, 1);
         chk("t5_rdy1",  bus.slv1_rdy, 0);
         chk("t5_data",  bus.proc_data, 32'h5000_0000 + 32'(c));
      end
      @(negedge clk); bus.slv0_data_valid = 1'b0; #1;
      chk("t5_cmplt", bus.mstr0_cmplt, 1);
      chk("t5_words", bus.job_words, 2);
      @(negedge clk); #1;
      @(negedge clk); #1;
      chk("t5_after_busy", bus.busy, 0);
      chk("t5_after_rdy1", bus.slv1_rdy, 0);
      clr();
      @(negedge clk);

      // T6: reset mid-job after two words, then a clean job.
      @(negedge clk);
      bus.slv1_data_valid = 1'b1; bus.slv1_mode = MODE_BRIGHT; bus.slv1_proc_val = 8'h66;
      bus.slv1_data = 32'h6000_0000; bus.slv1_last = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         bus.slv1_data = 32'h6000_0000 + 32'(c);
         #1;
         chk("t6_owner", bus.job_owner, 1);
         chk("t6_data",  bus.proc_data, 32'h6000_0000 + 32'(c));
      end
      @(negedge clk);
      bus.slv1_data = 32'h6000_0002;
      rst_n = 1'b0;
      #1 rst_chk("t6_rst");
      @(negedge clk); #1;
      chk("t6_rst_cmplt", bus.mstr0_cmplt, 0);
      chk("t6_rst_busy",  bus.busy, 0);
      clr();
      @(negedge clk); rst_n = 1'b1;
      #1 chk("t6_rel_cmplt", bus.mstr0_cmplt, 0);
      @(negedge clk);
      bus.slv0_data_valid = 1'b1; bus.slv0_mode = MODE_THRESH; bus.slv0_proc_val = 8'h77;
      bus.slv0_data = 32'h7000_0000; bus.slv0_last = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         bus.slv0_data = 32'h7000_0000 + 32'(c); bus.slv0_last = (c == 2);
         #1;
         chk("t6_new_owner", bus.job_owner, 0);
         chk("t6_new_data",  bus.proc_data, 32'h7000_0000 + 32'(c));
      end
      @(negedge clk); clr(); #1;
      chk("t6_new_cmplt", bus.mstr0_cmplt, 1);
      chk("t6_new_words", bus.job_words, 3);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
